// File: rtl/conv_pkg.sv
// Shared convolution-engine constants, reader FSM encoding and the tagged result word.
package conv_pkg;
  localparam int IMG_W  = 30;
  localparam int IMG_H  = 30;
  localparam int N_PIX  = IMG_W * IMG_H;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_t;

  typedef struct packed {
    logic              eol;
    logic              eof;
    logic [DATA_W-1:0] data;
  } rd_word_t;
endpackage

// File: rtl/conv_result_reader_skid_fifo2.sv
// Two-entry FIFO with head-of-queue output; push and pop in the same cycle are both honoured.
module skid_fifo2 #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      logic [W-1:0] entry_reg;
      always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
          entry_reg <= '0;
        else if (push && (wr_ptr_reg == 1'(gi)))
          entry_reg <= din;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + 2'(push) - 2'(pop);
    end
  end

  assign head  = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;
  assign count = count_reg;
endmodule

// File: rtl/conv_result_reader.sv
// Streams a finished result frame out of the sync-read RAM in raster order with eol/eof tags,
// keeping at most two words outstanding so backpressure never loses or repeats data.
module conv_result_reader
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_eol,
  output logic              o_eof,
  output logic              busy,
  output logic              done
);
  rd_state_t         state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [COL_W-1:0]  col_reg;
  logic [ROW_W-1:0]  row_reg;
  logic              inflight_reg;
  logic              eol_tag_reg, eof_tag_reg;
  logic [1:0]        fifo_count;
  rd_word_t          fifo_head;
  logic [2:0]        outstanding;
  logic              pop, issue, last_addr, col_last, row_last;

  assign pop         = o_valid && o_ready;
  assign outstanding = {1'b0, fifo_count} + {2'b0, inflight_reg};
  // A word popped this cycle frees its slot for a read issued in the same cycle.
  assign issue       = (state_reg == ST_READ) && (outstanding <= 3'd1 + {2'b0, pop});
  assign last_addr   = (addr_reg == ADDR_W'(N_PIX - 1));
  assign col_last    = (col_reg == COL_W'(IMG_W - 1));
  assign row_last    = (row_reg == ROW_W'(IMG_H - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_READ;
      ST_READ:  if (issue && last_addr) state_next = ST_DRAIN;
      // Leave when the final word is leaving now, so done lands the cycle after it.
      ST_DRAIN: if (!inflight_reg && (fifo_count == 2'd0 || (fifo_count == 2'd1 && pop)))
                  state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      col_reg      <= '0;
      row_reg      <= '0;
      inflight_reg <= 1'b0;
      eol_tag_reg  <= 1'b0;
      eof_tag_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= issue;
      if (issue) begin
        eol_tag_reg <= col_last;
        eof_tag_reg <= col_last && row_last;
        if (last_addr) begin
          addr_reg <= '0;
          col_reg  <= '0;
          row_reg  <= '0;
        end else begin
          addr_reg <= addr_reg + ADDR_W'(1);
          if (col_last) begin
            col_reg <= '0;
            row_reg <= row_reg + ROW_W'(1);
          end else begin
            col_reg <= col_reg + COL_W'(1);
          end
        end
      end
    end
  end

  skid_fifo2 #(.W($bits(rd_word_t))) u_fifo (
    .clk   (clk),
    .rstb  (rstb),
    .push  (inflight_reg),
    .pop   (pop),
    .din   ({eol_tag_reg, eof_tag_reg, mem_rd_data}),
    .head  (fifo_head),
    .count (fifo_count)
  );

  assign mem_rd_en   = issue;
  assign mem_rd_addr = addr_reg;
  assign o_valid     = (fifo_count != 2'd0);
  assign o_data      = fifo_head.data;
  assign o_eol       = fifo_head.eol;
  assign o_eof       = fifo_head.eof;
  assign busy        = (state_reg == ST_READ) || (state_reg == ST_DRAIN);
  assign done        = (state_reg == ST_DONE);
endmodule

// File: tb/tb_conv_result_reader.sv
// Scoreboard bench for conv_result_reader: a RAM model feeds the reader, expected words are queued
// at start and a monitor pops/compares on each transfer.
module tb_conv_result_reader;
  import conv_pkg::*;

  logic              clk = 1'b0;
  logic              rstb = 1'b0;
  logic              start = 1'b0;
  logic              o_ready = 1'b0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data = '0;
  logic              o_valid, o_eol, o_eof, busy, done;
  logic [DATA_W-1:0] o_data;

  typedef struct {
    logic [31:0] data;
    logic        eol;
    logic        eof;
  } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rx_cnt = 0;
  int last_xfer_cyc = 0;
  int outstanding = 0;
  int c0 = 0;
  logic rand_mode = 1'b0;
  logic stall_prev = 1'b0;
  logic [33:0] prev_word = '0;

  conv_result_reader dut (
    .clk(clk), .rstb(rstb), .start(start),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .o_eol(o_eol), .o_eof(o_eof), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] word_of(input int a);
    return 32'hA500_0000 | (32'(a) * 32'd3);
  endfunction

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= word_of(int'(mem_rd_addr));

  always @(posedge clk) begin
    #1;
    if (rand_mode) o_ready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboard pop/compare, stall stability and outstanding-word bound.
  always @(negedge clk) begin
    if (!rstb) begin
      stall_prev = 1'b0;
      outstanding = 0;
    end else begin
      if (mem_rd_en) outstanding++;
      if (stall_prev) begin
        check("hold_valid", 64'(o_valid), 64'd1);
        check("hold_word", 64'({o_eol, o_eof, o_data}), 64'(prev_word));
      end
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(o_data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check($sformatf("data[%0d]", rx_cnt), 64'(o_data), 64'(e.data));
          check($sformatf("eol[%0d]", rx_cnt), 64'(o_eol), 64'(e.eol));
          check($sformatf("eof[%0d]", rx_cnt), 64'(o_eof), 64'(e.eof));
        end
        rx_cnt++;
        last_xfer_cyc = cyc;
        outstanding--;
      end
      check("outstanding_gt2", 64'(outstanding > 2), 64'd0);
      stall_prev = o_valid && !o_ready;
      prev_word  = {o_eol, o_eof, o_data};
    end
  end

  task automatic push_frame();
    for (int i = 0; i < N_PIX; i++) begin
      exp_t e;
      e.data = word_of(i);
      e.eol  = ((i % IMG_W) == IMG_W - 1);
      e.eof  = (i == N_PIX - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic expect_frame);
    @(posedge clk); #1;
    start = 1'b1;
    if (expect_frame) begin
      push_frame();
      rx_cnt = 0;
    end
    @(posedge clk); #1;
    c0 = cyc;
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
    check({tag, "_rd_addr"}, 64'(mem_rd_addr), 64'd0);
    check({tag, "_valid"}, 64'(o_valid), 64'd0);
    check({tag, "_data"}, 64'(o_data), 64'd0);
    check({tag, "_eol_eof"}, 64'({o_eol, o_eof}), 64'd0);
    check({tag, "_busy_done"}, 64'({busy, done}), 64'd0);
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_cnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("rx_reached", 64'(rx_cnt >= n), 64'd1);
  endtask

  task automatic wait_done(input int budget);
    int   k = 0;
    logic got = 1'b0;
    while (!got && k < budget) begin
      @(negedge clk);
      k++;
      if (done) got = 1'b1;
    end
    check("done_seen", 64'(got), 64'd1);
    if (got) begin
      check("done_gap", 64'(cyc - last_xfer_cyc), 64'd1);
      check("busy_at_done", 64'(busy), 64'd0);
      check("words_rx", 64'(rx_cnt), 64'(N_PIX));
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      check("done_one_cycle", 64'(done), 64'd0);
    end
  endtask

  task automatic full_frame_ready_high(input string tag);
    o_ready = 1'b1;
    pulse_start(1'b1);
    @(negedge clk);
    check({tag, "_busy_e0"}, 64'(busy), 64'd1);
    check({tag, "_first_rd"}, 64'({mem_rd_en, mem_rd_addr}), 64'({1'b1, ADDR_W'(0)}));
    check({tag, "_valid_e0"}, 64'(o_valid), 64'd0);
    @(negedge clk);
    check({tag, "_valid_e1"}, 64'(o_valid), 64'd0);
    @(negedge clk);
    check({tag, "_valid_e2"}, 64'(o_valid), 64'd1);
    wait_done(2000);
    check({tag, "_last_xfer"}, 64'(last_xfer_cyc), 64'(c0 + 2 + N_PIX - 1));
  endtask

  initial begin
    int   n_rd;
    logic [ADDR_W-1:0] rd_addrs[2];

    // Reset held with start toggling.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      start = ~start;
      @(negedge clk);
      check_reset_outputs("rst");
    end
    @(posedge clk); #1;
    start = 1'b0;
    rstb  = 1'b1;

    full_frame_ready_high("frame1");

    // Random backpressure.
    rand_mode = 1'b1;
    pulse_start(1'b1);
    wait_done(20000);
    rand_mode = 1'b0;

    // Stall: ready low for 50 clocks after start.
    @(posedge clk); #1;
    o_ready = 1'b0;
    pulse_start(1'b1);
    n_rd = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_rd_en) begin
        if (n_rd < 2) rd_addrs[n_rd] = mem_rd_addr;
        n_rd++;
      end
    end
    check("stall_reads", 64'(n_rd), 64'd2);
    check("stall_addr0", 64'(rd_addrs[0]), 64'd0);
    check("stall_addr1", 64'(rd_addrs[1]), 64'd1);
    @(posedge clk); #1;
    o_ready = 1'b1;
    wait_done(2000);

    // Start while busy is ignored.
    pulse_start(1'b1);
    wait_rx(100, 2000);
    pulse_start(1'b0);
    wait_done(2000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_after_done", 64'({o_valid, busy, mem_rd_en}), 64'd0);
    end

    full_frame_ready_high("frame_after_done");

    // Reset mid-frame.
    pulse_start(1'b1);
    wait_rx(400, 2000);
    @(posedge clk); #1;
    rstb = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rstb = 1'b1;
    full_frame_ready_high("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
